// File: rtl/ram_lsu_if.sv
// ram_lsu_if: CPU request/response and data-RAM port bundle for the load/store unit.
interface ram_lsu_if #(
    parameter int AW = 18
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_data;
    logic          ram_wen;
    logic          ram_ren;
    logic [1:0]    ram_ben;
    logic [AW-3:0] ram_waddr;
    logic [AW-3:0] ram_raddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_data,
        input  ram_wen, ram_ren, ram_ben, ram_waddr, ram_raddr, ram_wdata
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_data,
        output ram_wen, ram_ren, ram_ben, ram_waddr, ram_raddr, ram_wdata
    );
endinterface

// File: rtl/ram_lsu.sv
// ram_lsu: byte-addressed load/store front end for a word RAM whose byte offset writes the whole upper tail.
// Sub-word stores that would clobber higher bytes are done as read-modify-write.
module ram_lsu #(
    parameter int AW = 18
) (
    input  logic     clk,
    input  logic     rst,
    ram_lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;
    state_t      state;
    logic        we;
    logic        uns;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [1:0]  off_in;
    logic [15:0] wd;
    logic        mis;
    logic        direct;
    logic [4:0]  sh;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld;
    logic [31:0] mrg;
    logic [31:0] dwd;
    always_comb begin
        off_in = bus.req_addr[1:0];
        mis    = (bus.req_size == 2'b11) | (bus.req_size == 2'b01 & off_in[0]) |
                 (bus.req_size == 2'b10 & off_in != 2'b00);
        // only stores reaching the top of the word can use the tail-write directly
        direct = (bus.req_size == 2'b10) | (bus.req_size == 2'b00 & off_in == 2'b11) |
                 (bus.req_size == 2'b01 & off_in == 2'b10);
        dwd    = bus.req_size == 2'b00 ? {24'h0, bus.req_wdata[7:0]} :
                 bus.req_size == 2'b01 ? {16'h0, bus.req_wdata[15:0]} : bus.req_wdata;
        sh     = {off, 3'b000};
        lb     = bus.ram_rdata[sh +: 8];
        lh     = off[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        ld     = size == 2'b00 ? {{24{~uns & lb[7]}}, lb} :
                 size == 2'b01 ? {{16{~uns & lh[15]}}, lh} : bus.ram_rdata;
        mrg    = size == 2'b00 ? (bus.ram_rdata & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh) :
                 {bus.ram_rdata[31:16], wd};
    end
    assign bus.req_ready = (state == IDLE) & ~rst;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            we            <= 1'b0;
            uns           <= 1'b0;
            size          <= 2'b00;
            off           <= 2'b00;
            wd            <= 16'h0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= 32'h0;
            bus.ram_wen   <= 1'b0;
            bus.ram_ren   <= 1'b0;
            bus.ram_ben   <= 2'b00;
            bus.ram_waddr <= '0;
            bus.ram_raddr <= '0;
            bus.ram_wdata <= 32'h0;
        end else begin
            bus.ram_wen   <= 1'b0;
            bus.ram_ren   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we            <= bus.req_we;
                    uns           <= bus.req_unsigned;
                    size          <= bus.req_size;
                    off           <= off_in;
                    wd            <= bus.req_wdata[15:0];
                    bus.ram_raddr <= bus.req_addr[AW-1:2];
                    bus.ram_waddr <= bus.req_addr[AW-1:2];
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_data  <= 32'h0;
                    if (mis) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else if (bus.req_we & direct) begin
                        state         <= WR;
                        bus.ram_wen   <= 1'b1;
                        bus.ram_ben   <= off_in;
                        bus.ram_wdata <= dwd;
                    end else begin
                        state       <= RD;
                        bus.ram_ren <= 1'b1;
                    end
                end
                RD: state <= RD_DATA;
                RD_DATA: if (we) begin
                    state         <= WR;
                    bus.ram_wen   <= 1'b1;
                    bus.ram_ben   <= 2'b00;
                    bus.ram_wdata <= mrg;
                end else begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= ld;
                end
                WR: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: scoreboard bench for ram_lsu against a tail-write RAM model.
module tb_ram_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ram_lsu_if #(.AW(18)) bus();
    ram_lsu #(.AW(18)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] mem [0:65535];
    logic        pk = 1'b0;
    logic [15:0] pk_a = 16'h0;
    logic [31:0] pk_d = 32'h0;
    int          cyc, n_ren, n_wen, wen_cyc;
    logic [1:0]  wen_ben;
    logic [31:0] wen_data;
    int          acc_q[$];
    int          total, bad;
    logic [32:0] exp_q[$];
    int          lat_q[$];
    // RAM model: ben=k writes wdata[31-8k:0] into mem[31:8k]; read data lands the cycle after ren
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pk) mem[pk_a] <= pk_d;
        else if (bus.ram_wen)
            mem[bus.ram_waddr] <= (mem[bus.ram_waddr] & ((32'h1 << {bus.ram_ben, 3'b000}) - 32'h1)) |
                                  (bus.ram_wdata << {bus.ram_ben, 3'b000});
        if (bus.ram_ren) begin
            bus.ram_rdata <= mem[bus.ram_raddr];
            n_ren <= n_ren + 1;
        end
        if (bus.ram_wen) begin
            n_wen    <= n_wen + 1;
            wen_cyc  <= cyc;
            wen_ben  <= bus.ram_ben;
            wen_data <= bus.ram_wdata;
        end
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    end

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        pk = 1'b1; pk_a = a; pk_d = d;
        @(negedge clk);
        pk = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns, input logic [17:0] addr,
                          input logic [31:0] wd, output int lat, output logic [32:0] rsp, output int t);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        lat = -1; rsp = '0;
        for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        t = cyc - 1;
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid) begin
                lat = cyc - t;
                rsp = {bus.rsp_err, bus.rsp_data};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", bus.req_ready); end
        total++; if ({bus.rsp_valid, bus.rsp_err, bus.ram_wen, bus.ram_ren} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got %b want 0000", {bus.rsp_valid, bus.rsp_err, bus.ram_wen, bus.ram_ren}); end
        total++; if ({bus.ram_ben, bus.ram_waddr, bus.ram_raddr} !== 34'h0) begin
            bad++; $display("FAIL reset_addr got %h want 0", {bus.ram_ben, bus.ram_waddr, bus.ram_raddr}); end
        total++; if ({bus.ram_wdata, bus.rsp_data} !== 64'h0) begin
            bad++; $display("FAIL reset_data got %h want 0", {bus.ram_wdata, bus.rsp_data}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
        logic        un [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [17:0] ad [7] = '{18'h16, 18'h16, 18'h14, 18'h14, 18'h14, 18'h15, 18'h3FFFC};
        logic [31:0] ev [7] = '{32'hFFFF_FFFF, 32'h0000_80FF, 32'h0000_0001, 32'h0000_7F01,
                                32'h80FF_7F01, 32'h0000_007F, 32'hC001_D00D};
        int lat, t, r0, w0, el;
        logic [32:0] r, ex;
        poke(16'd5, 32'h80FF_7F01);
        poke(16'hFFFF, 32'hC001_D00D);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({1'b0, ev[i]});
            lat_q.push_back(3);
            r0 = n_ren; w0 = n_wen;
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, r, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            total++; if (r !== ex) begin bad++; $display("FAIL load%0d_rsp got %h want %h", i, r, ex); end
            total++; if (lat !== el) begin bad++; $display("FAIL load%0d_lat got %0d want %0d", i, lat, el); end
            total++; if ({n_ren - r0, n_wen - w0} !== {32'd1, 32'd0}) begin
                bad++; $display("FAIL load%0d_strobes got ren=%0d wen=%0d want ren=1 wen=0", i, n_ren - r0, n_wen - w0); end
        end
    endtask

    task automatic test_rmw();
        logic [1:0]  sz [3] = '{2'b00, 2'b01, 2'b00};
        logic [17:0] ad [3] = '{18'h15, 18'h14, 18'h16};
        logic [31:0] wv [3] = '{32'hFFFF_FFAA, 32'h1234_BEEF, 32'h0000_0077};
        logic [31:0] mv [3] = '{32'h1122_AA44, 32'h1122_BEEF, 32'h1177_BEEF};
        int lat, t, r0, w0, el;
        logic [32:0] r, ex;
        poke(16'd5, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(33'h0);
            lat_q.push_back(4);
            r0 = n_ren; w0 = n_wen;
            do_req(1'b1, sz[i], 1'b0, ad[i], wv[i], lat, r, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            total++; if (r !== ex) begin bad++; $display("FAIL rmw%0d_rsp got %h want %h", i, r, ex); end
            total++; if (lat !== el) begin bad++; $display("FAIL rmw%0d_lat got %0d want %0d", i, lat, el); end
            total++; if ({n_ren - r0, n_wen - w0, wen_cyc - t} !== {32'd1, 32'd1, 32'd3}) begin
                bad++; $display("FAIL rmw%0d_strobes got ren=%0d wen=%0d at=%0d want 1 1 3", i, n_ren - r0, n_wen - w0, wen_cyc - t); end
            total++; if ({wen_ben, wen_data} !== {2'b00, mv[i]}) begin
                bad++; $display("FAIL rmw%0d_write got ben=%0d data=%h want ben=0 data=%h", i, wen_ben, wen_data, mv[i]); end
            total++; if (mem[5] !== mv[i]) begin bad++; $display("FAIL rmw%0d_mem got %h want %h", i, mem[5], mv[i]); end
        end
    endtask

    task automatic test_direct();
        logic [1:0]  sz [3] = '{2'b00, 2'b01, 2'b10};
        logic [17:0] ad [3] = '{18'h17, 18'h12, 18'h18};
        logic [31:0] wv [3] = '{32'h1234_565A, 32'hFFFF_BEEF, 32'hDEAD_BEEF};
        logic [1:0]  eb [3] = '{2'd3, 2'd2, 2'd0};
        logic [31:0] ew [3] = '{32'h0000_005A, 32'h0000_BEEF, 32'hDEAD_BEEF};
        logic [15:0] wa [3] = '{16'd5, 16'd4, 16'd6};
        logic [31:0] mv [3] = '{32'h5A22_3344, 32'hBEEF_F00D, 32'hDEAD_BEEF};
        int lat, t, r0, w0, el;
        logic [32:0] r, ex;
        poke(16'd5, 32'h1122_3344);
        poke(16'd4, 32'hCAFE_F00D);
        poke(16'd6, 32'h0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(33'h0);
            lat_q.push_back(2);
            r0 = n_ren; w0 = n_wen;
            do_req(1'b1, sz[i], 1'b0, ad[i], wv[i], lat, r, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            total++; if (r !== ex) begin bad++; $display("FAIL direct%0d_rsp got %h want %h", i, r, ex); end
            total++; if (lat !== el) begin bad++; $display("FAIL direct%0d_lat got %0d want %0d", i, lat, el); end
            total++; if ({n_ren - r0, n_wen - w0, wen_cyc - t} !== {32'd0, 32'd1, 32'd1}) begin
                bad++; $display("FAIL direct%0d_strobes got ren=%0d wen=%0d at=%0d want 0 1 1", i, n_ren - r0, n_wen - w0, wen_cyc - t); end
            total++; if ({wen_ben, wen_data} !== {eb[i], ew[i]}) begin
                bad++; $display("FAIL direct%0d_write got ben=%0d data=%h want ben=%0d data=%h", i, wen_ben, wen_data, eb[i], ew[i]); end
            total++; if (mem[wa[i]] !== mv[i]) begin bad++; $display("FAIL direct%0d_mem got %h want %h", i, mem[wa[i]], mv[i]); end
        end
    endtask

    task automatic test_misaligned();
        logic        we [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
        logic [17:0] ad [5] = '{18'h21, 18'h13, 18'h20, 18'h22, 18'h21};
        int lat, t, r0, w0, el;
        logic [32:0] r, ex;
        poke(16'd8, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b1, 32'h0});
            lat_q.push_back(1);
            r0 = n_ren; w0 = n_wen;
            do_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, lat, r, t);
            ex = exp_q.pop_front(); el = lat_q.pop_front();
            total++; if (r !== ex) begin bad++; $display("FAIL mis%0d_rsp got %h want %h", i, r, ex); end
            total++; if (lat !== el) begin bad++; $display("FAIL mis%0d_lat got %0d want %0d", i, lat, el); end
            total++; if ({n_ren - r0, n_wen - w0} !== {32'd0, 32'd0}) begin
                bad++; $display("FAIL mis%0d_strobes got ren=%0d wen=%0d want 0 0", i, n_ren - r0, n_wen - w0); end
        end
        total++; if (mem[8] !== 32'h1234_5678) begin bad++; $display("FAIL mis_mem got %h want 12345678", mem[8]); end
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        poke(16'd5, 32'h1122_3344);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 18'h15; bus.req_wdata = 32'hAA;
        w0 = n_wen;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (n_wen - w0 !== 0) begin bad++; $display("FAIL midrst_wen got %0d want 0", n_wen - w0); end
        total++; if (mem[5] !== 32'h1122_3344) begin bad++; $display("FAIL midrst_mem got %h want 11223344", mem[5]); end
        total++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL midrst_ready got ready=%b rsp=%b want 1 0", bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int n0, nr;
        int rc [2];
        logic [32:0] ex;
        poke(16'd9, 32'h0BAD_F00D);
        n0 = acc_q.size();
        nr = 0;
        rc[0] = 0; rc[1] = 0;
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 18'h24; bus.req_wdata = 32'h0;
        for (int k = 0; k < 30 && nr < 2; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ex = exp_q.pop_front();
                rc[nr] = cyc;
                total++; if ({bus.rsp_err, bus.rsp_data} !== ex) begin
                    bad++; $display("FAIL b2b%0d_rsp got %h want %h", nr, {bus.rsp_err, bus.rsp_data}, ex); end
                total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b%0d_ready got 1 want 0", nr); end
                nr++;
            end
        end
        bus.req_valid = 1'b0;
        total++; if (nr !== 2) begin bad++; $display("FAIL b2b_count got %0d want 2", nr); exp_q.delete(); end
        total++; if (rc[1] - rc[0] !== 4) begin bad++; $display("FAIL b2b_gap got %0d want 4", rc[1] - rc[0]); end
        total++; if (acc_q.size() - n0 < 2) begin bad++; $display("FAIL b2b_accepts got %0d want 2", acc_q.size() - n0); end
        else begin
            total++; if (acc_q[n0 + 1] - rc[0] !== 1) begin
                bad++; $display("FAIL b2b_accept_at got %0d want 1", acc_q[n0 + 1] - rc[0]); end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;
        total = 0; bad = 0;
        test_reset();
        test_loads();
        test_rmw();
        test_direct();
        test_misaligned();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
